// File: rtl/ram_2p_sync.sv
// Two-port word memory: a byte-masked data port and a stallable instruction-fetch port.
// Both reads are registered; a fetch forwards a same-cycle data write to the same word.
module ram_2p_sync #(
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 16384,
  parameter int                ADDR_W  = 32,
  parameter logic [DATA_W-1:0] NOP_INS = 32'h00000013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ce_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                derr_o,
  input  logic                inst_ce_i,
  input  logic                inst_stall_i,
  input  logic [ADDR_W-1:0]   pc_i,
  output logic                ins_valid_o,
  output logic [DATA_W-1:0]   ins_o,
  output logic                ierr_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOP_W = IDX_W + OFF_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_rvalid;
  logic [DATA_W-1:0] r_data;
  logic              r_derr;
  logic              r_ins_valid;
  logic [DATA_W-1:0] r_ins;
  logic              r_ierr;

  logic              w_d_ok;
  logic              w_i_ok;
  logic [IDX_W-1:0]  w_d_idx;
  logic [IDX_W-1:0]  w_i_idx;
  logic              w_wr_en;
  logic              w_hit;
  logic [DATA_W-1:0] w_i_word;
  logic [DATA_W-1:0] w_i_fwd;

  // Legal = aligned to a word and no address bit set above the index field.
  assign w_d_ok  = ~(|addr_i[OFF_W-1:0]) & ~(|addr_i[ADDR_W-1:TOP_W]);
  assign w_i_ok  = ~(|pc_i[OFF_W-1:0])   & ~(|pc_i[ADDR_W-1:TOP_W]);
  assign w_d_idx = addr_i[TOP_W-1:OFF_W];
  assign w_i_idx = pc_i[TOP_W-1:OFF_W];

  assign w_wr_en  = ~rst_i & ce_i & we_i & w_d_ok;
  assign w_hit    = w_wr_en & inst_ce_i & w_i_ok & (w_d_idx == w_i_idx);
  assign w_i_word = r_mem[w_i_idx];

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_fwd
    assign w_i_fwd[gi*8 +: 8] = (w_hit && sel_i[gi]) ? data_i[gi*8 +: 8] : w_i_word[gi*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (sel_i[k]) r_mem[w_d_idx][k*8 +: 8] <= data_i[k*8 +: 8];
      end
    end
  end

  // Data port: writes and idle cycles keep the last read data on data_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_data   <= '0;
      r_derr   <= 1'b0;
    end else if (ce_i) begin
      r_rvalid <= ~we_i;
      r_derr   <= ~w_d_ok;
      if (!we_i) r_data <= w_d_ok ? r_mem[w_d_idx] : '0;
    end else begin
      r_rvalid <= 1'b0;
      r_derr   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ins_valid <= 1'b0;
      r_ins       <= NOP_INS;
      r_ierr      <= 1'b0;
    end else if (!inst_stall_i) begin
      if (inst_ce_i) begin
        r_ins_valid <= 1'b1;
        r_ierr      <= ~w_i_ok;
        r_ins       <= w_i_ok ? w_i_fwd : NOP_INS;
      end else begin
        r_ins_valid <= 1'b0;
        r_ierr      <= 1'b0;
        r_ins       <= NOP_INS;
      end
    end
  end

  assign rvalid_o    = r_rvalid;
  assign data_o      = r_data;
  assign derr_o      = r_derr;
  assign ins_valid_o = r_ins_valid;
  assign ins_o       = r_ins;
  assign ierr_o      = r_ierr;

`ifdef RAM_SIMUTIL
  // Simulation-only backdoor access to the array, enabled by the simulation top.
  task automatic simutil_set_mem(input int index, input logic [DATA_W-1:0] val, output int ok);
    if (index < 0 || index >= DEPTH) begin
      ok = 0;
    end else begin
      r_mem[index] <= val;
      ok = 1;
    end
  endtask

  function automatic int simutil_get_mem(input int index, output logic [DATA_W-1:0] val);
    if (index < 0 || index >= DEPTH) begin
      val = '0;
      return 0;
    end
    val = r_mem[index];
    return 1;
  endfunction
`endif

endmodule

// File: tb/tb_ram_2p_sync.sv
// Bench for ram_2p_sync: directed scenarios followed by random traffic, all checked
// against a word-array model that applies each write before serving reads (write-first).
module tb_ram_2p_sync;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 16384;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int          MW     = 128;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        rvalid_o;
  logic [31:0] data_o;
  logic        derr_o;
  logic        inst_ce_i = 1'b0;
  logic        inst_stall_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ins_valid_o;
  logic [31:0] ins_o;
  logic        ierr_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [MW];
  logic        e_rvalid, e_derr, e_ivalid, e_ierr;
  logic [31:0] e_data, e_ins;

  always #5 clk_i = ~clk_i;

  ram_2p_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_INS(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .data_i(data_i), .rvalid_o(rvalid_o), .data_o(data_o),
    .derr_o(derr_o), .inst_ce_i(inst_ce_i), .inst_stall_i(inst_stall_i), .pc_i(pc_i),
    .ins_valid_o(ins_valid_o), .ins_o(ins_o), .ierr_o(ierr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic step(input bit rst, input bit ce, input bit we, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] din,
                      input bit ice, input bit istall, input logic [31:0] pc,
                      input string tag);
    int widx;
    rst_i = rst; ce_i = ce; we_i = we; sel_i = sel; addr_i = addr; data_i = din;
    inst_ce_i = ice; inst_stall_i = istall; pc_i = pc;
    if (rst) begin
      e_rvalid = 1'b0; e_data = '0; e_derr = 1'b0;
      e_ivalid = 1'b0; e_ins = NOP; e_ierr = 1'b0;
    end else begin
      if (ce && we && legal(addr)) begin
        widx = int'(addr / 4);
        for (int k = 0; k < 4; k++) if (sel[k]) mdl[widx][8*k +: 8] = din[8*k +: 8];
      end
      if (ce) begin
        e_rvalid = !we;
        e_derr   = !legal(addr);
        if (!we) e_data = legal(addr) ? mdl[int'(addr / 4)] : 32'h0;
      end else begin
        e_rvalid = 1'b0;
        e_derr   = 1'b0;
      end
      if (!istall) begin
        if (ice) begin
          e_ivalid = 1'b1;
          e_ierr   = !legal(pc);
          e_ins    = legal(pc) ? mdl[int'(pc / 4)] : NOP;
        end else begin
          e_ivalid = 1'b0;
          e_ierr   = 1'b0;
          e_ins    = NOP;
        end
      end
    end
    @(posedge clk_i);
    #1;
    chk({tag, ".rvalid"}, {31'h0, rvalid_o}, {31'h0, e_rvalid});
    chk({tag, ".data"}, data_o, e_data);
    chk({tag, ".derr"}, {31'h0, derr_o}, {31'h0, e_derr});
    chk({tag, ".ivalid"}, {31'h0, ins_valid_o}, {31'h0, e_ivalid});
    chk({tag, ".ins"}, ins_o, e_ins);
    chk({tag, ".ierr"}, {31'h0, ierr_o}, {31'h0, e_ierr});
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = 32'($urandom_range(0, MW - 1)) * 4;
    case ($urandom_range(0, 9))
      0:       return w | 32'($urandom_range(1, 3));
      1:       return w | (32'h00010000 << $urandom_range(0, 15));
      default: return w;
    endcase
  endfunction

  initial begin
    logic [31:0] a, p, v;
    // Reset with a write pending: outputs go to reset values.
    step(1, 1, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h0, "rst0");
    step(1, 1, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 1, 0, 32'h0, "rst1");
    chk("rst.ins_const", ins_o, NOP);

    for (int i = 0; i < MW; i++) begin
      v = (i < 4) ? 32'(i + 1) : $urandom;
      step(0, 1, 1, 4'hF, 32'(i * 4), v, 0, 0, 32'h0, "preload");
    end

    // A write presented during reset must not reach memory.
    step(1, 1, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 0, 0, 32'h0, "rstw0");
    step(1, 1, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 0, 0, 32'h0, "rstw1");
    step(0, 1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, "rstw_rd");
    chk("rstw.mem0", data_o, 32'h1);

    // Byte-masked writes then read back.
    step(0, 1, 1, 4'hF, 32'h100, 32'hAABBCCDD, 0, 0, 32'h0, "bw0");
    step(0, 1, 1, 4'b0101, 32'h100, 32'h11223344, 0, 0, 32'h0, "bw1");
    step(0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0, "bw_rd");
    chk("bw.merge", data_o, 32'hAA22CC44);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, "bw_idle");
    chk("bw.hold", data_o, 32'hAA22CC44);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 4'h0, 32'(i * 4), 32'h0, 0, 0, 32'h0, "pipe");
      chk("pipe.const", data_o, 32'(i + 1));
    end

    // Error cases.
    step(0, 1, 0, 4'h0, 32'h102, 32'h0, 0, 0, 32'h0, "mis_rd");
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h00010000, "oor_fetch");
    chk("oor.ins_const", ins_o, 32'h00000013);
    step(0, 1, 1, 4'hF, 32'h103, 32'h55555555, 0, 0, 32'h0, "mis_wr");
    step(0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0, "mis_wr_rd");
    chk("mis_wr.const", data_o, 32'hAA22CC44);

    // Write/fetch collision on word 8.
    step(0, 1, 1, 4'hF, 32'h20, 32'h0, 0, 0, 32'h0, "col_clr");
    step(0, 1, 1, 4'b0011, 32'h20, 32'hDEADBEEF, 1, 0, 32'h20, "col");
    chk("col.fwd_const", ins_o, 32'h0000BEEF);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h20, "col_refetch");
    chk("col.refetch_const", ins_o, 32'h0000BEEF);

    // Stall holds the fetch registers while pc advances.
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, "st_fetch");
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'(i * 4), "stall");
      chk("stall.ins_const", ins_o, 32'h1);
    end
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h10, "st_release");
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, "st_fetch2");
    step(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h4, "st_hold");
    step(1, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h4, "st_rst");
    chk("st_rst.ins_const", ins_o, NOP);

    // Random traffic; fetch often targets the written word to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      a = rand_addr();
      p = ($urandom_range(0, 3) == 0) ? a : rand_addr();
      step($urandom_range(0, 24) == 0, 1'($urandom), 1'($urandom), 4'($urandom),
           a, $urandom, 1'($urandom), $urandom_range(0, 4) == 0, p, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
